// File: rtl/mem_wb_pkg.sv
// Shared opcode constants for MEM/WB, decode and forwarding.
// Bubbles reuse the SW opcode because the forwarding unit never forwards SW.
package mem_wb_pkg;

  localparam logic [3:0] OP_BRANCH     = 4'b0010;
  localparam logic [3:0] OP_SW         = 4'b0011;
  localparam logic [3:0] OP_LW         = 4'b0100;
  localparam logic [3:0] BUBBLE_OPCODE = OP_SW;

  typedef logic [7:0] cnt_t;

  // Only BRANCH and SW leave the register file untouched
  function automatic logic writes_rf(input logic [3:0] op);
    return (op != OP_BRANCH) && (op != OP_SW);
  endfunction

endpackage

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register with load-data wait state.
// A load missing its read data parks here and stalls the pipe.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int bitwidth            = 32,
  parameter int LOAD_TIMEOUT        = 15
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_valid,
  input  logic [3:0]                     mem_opcode,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] mem_index,
  input  logic [bitwidth-1:0]            mem_alu_result,
  input  logic [bitwidth-1:0]            dmem_rdata,
  input  logic                           dmem_rvalid,
  input  logic                           stall_in,
  input  logic                           flush_in,
  output logic [3:0]                     wb_opcode,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wb_index,
  output logic [bitwidth-1:0]            wb_data,
  output logic                           wb_we,
  output logic                           load_stall,
  output logic                           load_err
);

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

  localparam cnt_t CNT_LAST = cnt_t'(LOAD_TIMEOUT - 1);

  state_e                         state_q, state_d;
  logic [3:0]                     op_q, op_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] idx_q, idx_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] lidx_q, lidx_d;
  logic [bitwidth-1:0]            data_q, data_d;
  logic                           we_q, we_d;
  logic                           stall_q, stall_d;
  logic                           err_q, err_d;
  cnt_t                           cnt_q, cnt_d;
  logic                           bubble;

  // Next-state: flush beats load wait, load wait beats stall
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    data_d  = data_q;
    we_d    = we_q;
    stall_d = stall_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;
    if (flush_in) begin
      bubble  = 1'b1;
      stall_d = 1'b0;
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == LOAD_WAIT) begin
      if (dmem_rvalid) begin
        op_d    = OP_LW;
        idx_d   = lidx_q;
        data_d  = dmem_rdata;
        we_d    = 1'b1;
        stall_d = 1'b0;
        state_d = RUN;
      end else if (cnt_q == CNT_LAST) begin
        err_d   = 1'b1;
        bubble  = 1'b1;
        stall_d = 1'b0;
        state_d = RUN;
        cnt_d   = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end else if (stall_in) begin
      // hold everything
    end else if (!mem_valid) begin
      bubble = 1'b1;
    end else if (mem_opcode == OP_LW) begin
      if (dmem_rvalid) begin
        op_d   = OP_LW;
        idx_d  = mem_index;
        data_d = dmem_rdata;
        we_d   = 1'b1;
      end else begin
        lidx_d  = mem_index;
        bubble  = 1'b1;
        stall_d = 1'b1;
        cnt_d   = '0;
        state_d = LOAD_WAIT;
      end
    end else begin
      op_d   = mem_opcode;
      idx_d  = mem_index;
      data_d = mem_alu_result;
      we_d   = writes_rf(mem_opcode);
    end
    if (bubble) begin
      op_d   = BUBBLE_OPCODE;
      idx_d  = '0;
      data_d = '0;
      we_d   = 1'b0;
    end
  end

  // State and output registers, bubble on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      op_q    <= BUBBLE_OPCODE;
      idx_q   <= '0;
      lidx_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      lidx_q  <= lidx_d;
      data_q  <= data_d;
      we_q    <= we_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_opcode  = op_q;
  assign wb_index   = idx_q;
  assign wb_data    = data_q;
  assign wb_we      = we_q;
  assign load_stall = stall_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios then random traffic
// against a transaction-level reference model.
module tb_mem_wb_stage;

  localparam int IW = 4;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [3:0] OP_BR = 4'b0010;
  localparam logic [3:0] OP_SW = 4'b0011;
  localparam logic [3:0] OP_LW = 4'b0100;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_valid;
  logic [3:0]    mem_opcode;
  logic [IW-1:0] mem_index;
  logic [DW-1:0] mem_alu_result;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_rvalid;
  logic          stall_in;
  logic          flush_in;
  logic [3:0]    wb_opcode;
  logic [IW-1:0] wb_index;
  logic [DW-1:0] wb_data;
  logic          wb_we;
  logic          load_stall;
  logic          load_err;

  mem_wb_stage #(
    .REG_INDEX_BIT_WIDTH(IW),
    .bitwidth(DW),
    .LOAD_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_valid(mem_valid),
    .mem_opcode(mem_opcode),
    .mem_index(mem_index),
    .mem_alu_result(mem_alu_result),
    .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid),
    .stall_in(stall_in),
    .flush_in(flush_in),
    .wb_opcode(wb_opcode),
    .wb_index(wb_index),
    .wb_data(wb_data),
    .wb_we(wb_we),
    .load_stall(load_stall),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]    m_op;
  logic [IW-1:0] m_idx;
  logic [IW-1:0] m_lidx;
  logic [DW-1:0] m_data;
  logic          m_we;
  logic          m_stall;
  logic          m_err;
  logic          m_wait;
  int            m_waited;

  function automatic void m_bubble();
    m_op   = OP_SW;
    m_idx  = '0;
    m_data = '0;
    m_we   = 1'b0;
  endfunction

  function automatic void m_reset();
    m_bubble();
    m_stall  = 1'b0;
    m_err    = 1'b0;
    m_wait   = 1'b0;
    m_waited = 0;
    m_lidx   = '0;
  endfunction

  // One clock edge of the reference, using the inputs now applied
  function automatic void m_step();
    if (flush_in) begin
      m_bubble();
      m_wait   = 1'b0;
      m_waited = 0;
    end else if (m_wait) begin
      if (dmem_rvalid) begin
        m_op   = OP_LW;
        m_idx  = m_lidx;
        m_data = dmem_rdata;
        m_we   = 1'b1;
        m_wait = 1'b0;
      end else begin
        m_waited++;
        if (m_waited >= TO) begin
          m_err  = 1'b1;
          m_bubble();
          m_wait = 1'b0;
        end
      end
    end else if (stall_in) begin
      m_wait = 1'b0;
    end else if (!mem_valid) begin
      m_bubble();
    end else if (mem_opcode == OP_LW) begin
      if (dmem_rvalid) begin
        m_op   = OP_LW;
        m_idx  = mem_index;
        m_data = dmem_rdata;
        m_we   = 1'b1;
      end else begin
        m_lidx   = mem_index;
        m_bubble();
        m_wait   = 1'b1;
        m_waited = 0;
      end
    end else begin
      m_op   = mem_opcode;
      m_idx  = mem_index;
      m_data = mem_alu_result;
      m_we   = (mem_opcode != OP_BR) && (mem_opcode != OP_SW);
    end
    m_stall = m_wait;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_op"},    64'(wb_opcode),  64'(m_op));
    chk({tag, "_idx"},   64'(wb_index),   64'(m_idx));
    chk({tag, "_data"},  64'(wb_data),    64'(m_data));
    chk({tag, "_we"},    64'(wb_we),      64'(m_we));
    chk({tag, "_stall"}, 64'(load_stall), 64'(m_stall));
    chk({tag, "_err"},   64'(load_err),   64'(m_err));
  endtask

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid      = 1'b0;
    mem_opcode     = 4'h0;
    mem_index      = '0;
    mem_alu_result = '0;
    dmem_rdata     = '0;
    dmem_rvalid    = 1'b0;
    stall_in       = 1'b0;
    flush_in       = 1'b0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [IW-1:0] idx,
                       input logic [DW-1:0] alu);
    mem_valid      = 1'b1;
    mem_opcode     = op;
    mem_index      = idx;
    mem_alu_result = alu;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    m_reset();
    #3;
    chk_all("reset");
    chk("reset_op_const", 64'(wb_opcode), 64'(OP_SW));
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ALU capture
    instr(4'b0000, 4'd5, 32'h1234);
    step();
    chk_all("add");
    chk("add_data_const", 64'(wb_data), 64'h1234);
    chk("add_we_const", 64'(wb_we), 64'h1);

    // SW and BRANCH do not write
    instr(OP_SW, 4'd3, 32'h77);
    step();
    chk_all("sw");
    chk("sw_we_const", 64'(wb_we), 64'h0);
    instr(OP_BR, 4'd3, 32'h88);
    step();
    chk_all("br");
    chk("br_op_const", 64'(wb_opcode), 64'(OP_BR));

    // Load waits three cycles for data
    instr(OP_LW, 4'd7, 32'h0);
    step();
    chk_all("lw_w0");
    chk("lw_stall_const", 64'(load_stall), 64'h1);
    idle();
    step();
    chk_all("lw_w1");
    step();
    chk_all("lw_w2");
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    step();
    chk_all("lw_done");
    chk("lw_data_const", 64'(wb_data), 64'hDEAD_BEEF);
    chk("lw_idx_const", 64'(wb_index), 64'd7);
    idle();

    // Timeout with no read data
    instr(OP_LW, 4'd9, 32'h0);
    step();
    chk_all("to_w0");
    idle();
    for (int i = 1; i < TO; i++) begin
      step();
      chk_all("to_wait");
    end
    step();
    chk_all("to_abort");
    chk("to_err_const", 64'(load_err), 64'h1);
    chk("to_stall_const", 64'(load_stall), 64'h0);
    instr(4'b0001, 4'd4, 32'hABCD);
    step();
    chk_all("to_sticky");

    // Flush beats rvalid while a load waits
    instr(OP_LW, 4'd2, 32'h0);
    step();
    chk_all("fl_wait");
    idle();
    flush_in    = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    step();
    chk_all("fl_drop");
    chk("fl_we_const", 64'(wb_we), 64'h0);
    idle();

    // Async reset between edges, then stall hold
    instr(4'b0000, 4'd1, 32'hCAFE);
    step();
    chk_all("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk_all("async_rst");
    chk("async_we_const", 64'(wb_we), 64'h0);
    #1;
    rst = 1'b0;
    instr(4'b0000, 4'd6, 32'h55);
    step();
    chk_all("st_cap");
    stall_in = 1'b1;
    instr(4'b0001, 4'd2, 32'h99);
    step();
    chk_all("st_hold1");
    step();
    chk_all("st_hold2");
    chk("st_data_const", 64'(wb_data), 64'h55);
    idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      mem_valid      = ($urandom_range(0, 3) != 0);
      mem_opcode     = ($urandom_range(0, 7) < 3) ? OP_LW
                       : 4'($urandom_range(0, 15));
      mem_index      = IW'($urandom);
      mem_alu_result = $urandom;
      dmem_rdata     = $urandom;
      dmem_rvalid    = ($urandom_range(0, 3) == 0);
      stall_in       = ($urandom_range(0, 4) == 0);
      flush_in       = ($urandom_range(0, 19) == 0);
      step();
      chk_all("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Pipeline register between the MEM stage and the WB stage.
- Drives the wb_opcode/wb_index/wb_data bus consumed by the WB forwarding unit and the register-file write port.
- Captures ALU results in one cycle. Holds load instructions in a wait state until data-memory read data returns, and stalls the pipeline meanwhile.
- Emits a bubble encoding that the forwarding unit ignores.

Parameters:
- REG_INDEX_BIT_WIDTH, 4, register index width
- bitwidth, 32, datapath width
- LOAD_TIMEOUT, 15, max cycles waited in LOAD_WAIT before abort; 1..255

Ports:
- clk  input  1  pipeline clock
- rst  input  1  reset; asynchronous, active-high
- mem_valid  input  1  MEM stage holds a real instruction this cycle
- mem_opcode  input  4  instruction opcode
- mem_index  input  REG_INDEX_BIT_WIDTH  destination register index
- mem_alu_result  input  bitwidth  ALU result
- dmem_rdata  input  bitwidth  data-memory read data
- dmem_rvalid  input  1  dmem_rdata valid this cycle
- stall_in  input  1  hold stage contents
- flush_in  input  1  discard stage contents
- wb_opcode  output  4  registered opcode to WB / forwarding unit
- wb_index  output  REG_INDEX_BIT_WIDTH  registered destination index
- wb_data  output  bitwidth  registered write-back data
- wb_we  output  1  register-file write enable
- load_stall  output  1  pipeline stall request while a load waits
- load_err  output  1  sticky load-timeout flag

Behaviour:
- Opcodes: BRANCH=4'b0010, SW=4'b0011, LW=4'b0100.
- Bubble: wb_opcode=SW, wb_index=0, wb_data=0, wb_we=0. The forwarding unit never forwards SW, so a bubble is invisible to it.
- Reset (async, immediate): bubble outputs, load_stall=0, load_err=0, state RUN, timeout counter 0.
- Per-edge priority: rst > flush_in > LOAD_WAIT handling > stall_in > capture.
- State RUN:
  - stall_in=1: all outputs hold. A repeated wb_we write of the same value is accepted as idempotent.
  - mem_valid=0: register a bubble.
  - mem_valid=1, opcode not LW: wb_opcode/index <= mem_*, wb_data <= mem_alu_result, wb_we <= (opcode not BRANCH and not SW). Latency 1 cycle.
  - mem_valid=1, opcode LW, dmem_rvalid=1 on the same edge: wb_data <= dmem_rdata, wb_we=1. Latency 1 cycle.
  - mem_valid=1, opcode LW, dmem_rvalid=0: latch index internally, register a bubble, set load_stall=1, clear counter, go to LOAD_WAIT.
- State LOAD_WAIT (stall_in is ignored):
  - dmem_rvalid=1: wb_opcode=LW, wb_index=latched index, wb_data=dmem_rdata, wb_we=1, load_stall=0, go to RUN.
  - Otherwise increment the counter. At the edge where counter==LOAD_TIMEOUT-1 with no rvalid: load_err=1 (sticky until rst), bubble out, load_stall=0, go to RUN.
  - load_stall is registered and high exactly while in LOAD_WAIT.
- flush_in=1 in any state: bubble out, load_stall=0, go to RUN, counter cleared, load_err unchanged.
  - An rvalid arriving on the flush edge is discarded.
- dmem_rvalid in RUN without a pending LW is ignored.
- No arithmetic beyond the 8-bit counter. The counter saturates rather than wraps.

Decomposition:
- Shared opcode-define file holds BRANCH, SW, LW and the BUBBLE_OPCODE (=SW) constant. The forwarding unit, this block and decode all include it.
- State encoding is a local 1-bit state (RUN=0, LOAD_WAIT=1).
- No sub-module is needed. The timeout counter stays inline.

Test Plan:
- ADD capture: mem_valid=1, opcode=4'b0000, index=5, alu=32'h1234 -> next cycle wb_opcode=0, wb_index=5, wb_data=32'h1234, wb_we=1.
- SW/BRANCH suppress: opcode=SW, index=3 -> wb_opcode=SW, wb_we=0. Same check for BRANCH.
- Load wait: LW index=7, rvalid low for 3 cycles, then rdata=32'hDEAD_BEEF:
  - load_stall=1 for 3 cycles with bubble outputs.
  - Then wb_opcode=LW, wb_index=7, wb_data=32'hDEADBEEF, wb_we=1, load_stall=0.
- Timeout: LOAD_TIMEOUT=4, LW, rvalid never asserted -> load_stall high 4 cycles, then load_err=1, bubble, RUN. load_err persists through later instructions.
- Flush mid-load: LW pending, flush_in=1 coincident with rvalid=1 -> bubble, load_stall=0, wb_we=0, rdata dropped.
- Async reset and stall: assert rst between clock edges with wb_we=1 -> outputs go to bubble immediately. After release, stall_in=1 for 2 cycles holds captured ADD values unchanged.
